// File: rtl/clock_timekeeper.sv
// clock_timekeeper: time-of-day core of the 7-segment clock.
// Synchronises the 32.768 kHz reference, derives the 1 Hz, set and debounce
// strobes, conditions the three setting buttons and keeps hours, minutes and
// seconds in binary. Define CLOCK_BUTTON_DEBOUNCE_EN to filter the buttons;
// without it the buttons are only two-flop synchronised.
module clock_timekeeper #(
    parameter int unsigned REFCLK_BITS      = 15,
    parameter int unsigned DEBOUNCE_SAMPLES = 3
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_refclk,
    input  logic       i_fast_set,
    input  logic       i_set_hours,
    input  logic       i_set_minutes,
    output logic [4:0] o_hours,
    output logic [5:0] o_minutes,
    output logic [5:0] o_seconds,
    output logic       o_1hz_stb
);

    localparam int unsigned BtnFast    = 0;
    localparam int unsigned BtnHours   = 1;
    localparam int unsigned BtnMinutes = 2;
    localparam logic [REFCLK_BITS-1:0] CntOne = 1;

    if (REFCLK_BITS < 9) begin : gen_bad_refclk_bits
        $error("clock_timekeeper: REFCLK_BITS must be at least 9");
    end
    if (DEBOUNCE_SAMPLES < 2 || DEBOUNCE_SAMPLES > 8) begin : gen_bad_debounce_samples
        $error("clock_timekeeper: DEBOUNCE_SAMPLES must be in 2..8");
    end

    logic [1:0]             ref_sync_q;
    logic                   ref_prev_q;
    logic                   ref_edge_q;
    logic [REFCLK_BITS-1:0] cnt_q;
    logic                   stb_1hz_q;
    logic                   stb_slow_q;
    logic                   stb_fast_q;
    logic [2:0]             btn_meta_q;
    logic [2:0]             btn_sync_q;
    logic [2:0]             btn;
    logic                   set_stb;
    logic [4:0]             hours_q, hours_d;
    logic [5:0]             minutes_q, minutes_d;
    logic [5:0]             seconds_q, seconds_d;
    logic                   out_stb_q;

    // Two-flop synchroniser on the reference clock plus a registered rising-edge detect.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ref_sync_q <= '0;
            ref_prev_q <= 1'b0;
            ref_edge_q <= 1'b0;
        end else begin
            ref_sync_q <= {ref_sync_q[0], i_refclk};
            ref_prev_q <= ref_sync_q[1];
            ref_edge_q <= ref_sync_q[1] & ~ref_prev_q;
        end
    end

    // Count reference edges; a strobe fires when its low bits of the count wrap to zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q      <= '0;
            stb_1hz_q  <= 1'b0;
            stb_slow_q <= 1'b0;
            stb_fast_q <= 1'b0;
        end else begin
            if (ref_edge_q) begin
                cnt_q <= cnt_q + CntOne;
            end
            stb_1hz_q  <= ref_edge_q & (&cnt_q);
            stb_slow_q <= ref_edge_q & (&cnt_q[REFCLK_BITS-2:0]);
            stb_fast_q <= ref_edge_q & (&cnt_q[REFCLK_BITS-4:0]);
        end
    end

    // Two-flop synchronisers for the raw buttons.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
        end else begin
            btn_meta_q <= {i_set_minutes, i_set_hours, i_fast_set};
            btn_sync_q <= btn_meta_q;
        end
    end

`ifdef CLOCK_BUTTON_DEBOUNCE_EN
    logic                                 stb_deb_q;
    logic [2:0][DEBOUNCE_SAMPLES-1:0]     hist_q, hist_d;
    logic [2:0]                           btn_db_q, btn_db_d;

    // 256 Hz sampling strobe for the debouncer.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stb_deb_q <= 1'b0;
        end else begin
            stb_deb_q <= ref_edge_q & (&cnt_q[REFCLK_BITS-9:0]);
        end
    end

    // Shift each level into its history; accept a new level only once the history is unanimous.
    always_comb begin
        hist_d   = hist_q;
        btn_db_d = btn_db_q;
        if (stb_deb_q) begin
            for (int b = 0; b < 3; b++) begin
                hist_d[b] = {hist_q[b][DEBOUNCE_SAMPLES-2:0], btn_sync_q[b]};
                if (&hist_d[b]) begin
                    btn_db_d[b] = 1'b1;
                end else if (~|hist_d[b]) begin
                    btn_db_d[b] = 1'b0;
                end
            end
        end
    end

    // Debounce history and accepted levels.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hist_q   <= '0;
            btn_db_q <= '0;
        end else begin
            hist_q   <= hist_d;
            btn_db_q <= btn_db_d;
        end
    end

    assign btn = btn_db_q;
`else
    assign btn = btn_sync_q;
`endif

    // Fast-set level registered before this cycle picks the set rate.
    assign set_stb = btn[BtnFast] ? stb_fast_q : stb_slow_q;

    // Next time of day: set modes take priority and mask the 1 Hz strobe.
    always_comb begin
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        if (btn[BtnHours] && btn[BtnMinutes]) begin
            seconds_d = '0;
        end else if (btn[BtnHours]) begin
            if (set_stb) begin
                hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
            end
        end else if (btn[BtnMinutes]) begin
            if (set_stb) begin
                minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
            end
        end else if (stb_1hz_q) begin
            if (seconds_q == 6'd59) begin
                seconds_d = '0;
                if (minutes_q == 6'd59) begin
                    minutes_d = '0;
                    hours_d   = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                end else begin
                    minutes_d = minutes_q + 6'd1;
                end
            end else begin
                seconds_d = seconds_q + 6'd1;
            end
        end
    end

    // Time registers; the output strobe lines up with the incremented time.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hours_q   <= '0;
            minutes_q <= '0;
            seconds_q <= '0;
            out_stb_q <= 1'b0;
        end else begin
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            seconds_q <= seconds_d;
            out_stb_q <= stb_1hz_q;
        end
    end

    assign o_hours   = hours_q;
    assign o_minutes = minutes_q;
    assign o_seconds = seconds_q;
    assign o_1hz_stb = out_stb_q;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Testbench for clock_timekeeper (REFCLK_BITS = 9, DEBOUNCE_SAMPLES = 3).
// Reference edges get randomised high/low widths; the expected time of day is
// computed from the total edge count and the buttons held.
`timescale 1ns/1ps
module tb_clock_timekeeper;
    localparam int unsigned RefBits     = 9;
    localparam int unsigned Samples     = 3;
    localparam int          EdgesPerSec = 512;
    localparam int          EdgesSlow   = 256;
    localparam int          EdgesFast   = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       refclk;
    logic       fast_set;
    logic       set_hours;
    logic       set_minutes;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       stb_1hz;

    clock_timekeeper #(
        .REFCLK_BITS     (RefBits),
        .DEBOUNCE_SAMPLES(Samples)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_refclk     (refclk),
        .i_fast_set   (fast_set),
        .i_set_hours  (set_hours),
        .i_set_minutes(set_minutes),
        .o_hours      (hours),
        .o_minutes    (minutes),
        .o_seconds    (seconds),
        .o_1hz_stb    (stb_1hz)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    int m_edges, m_hours, m_minutes, m_seconds, m_1hz, m_steps;
    bit eb_fast, eb_hours, eb_minutes;
    int dut_1hz = 0;

    // Cycles with the 1 Hz output high since the last reset
    always @(negedge clk) begin
        if (reset) dut_1hz <= 0;
        else if (stb_1hz) dut_1hz <= dut_1hz + 1;
    end

    function automatic logic [16:0] exp_time();
        return {5'(m_hours), 6'(m_minutes), 6'(m_seconds)};
    endfunction

    task automatic model_reset();
        m_edges = 0; m_hours = 0; m_minutes = 0; m_seconds = 0; m_1hz = 0; m_steps = 0;
        eb_fast = 0; eb_hours = 0; eb_minutes = 0;
    endtask

    // Apply one reference edge to the model: strobe n fires when edge count is a multiple.
    task automatic model_edge();
        bit one_hz, slow, fast, set;
        int tod;
        m_edges++;
        one_hz = (m_edges % EdgesPerSec) == 0;
        slow   = (m_edges % EdgesSlow) == 0;
        fast   = (m_edges % EdgesFast) == 0;
        set    = eb_fast ? fast : slow;
        if (one_hz) m_1hz++;
        if (eb_hours && eb_minutes) begin
            m_seconds = 0;
        end else if (eb_hours) begin
            if (set) begin m_hours = (m_hours + 1) % 24; m_steps++; end
        end else if (eb_minutes) begin
            if (set) begin m_minutes = (m_minutes + 1) % 60; m_steps++; end
        end else if (one_hz) begin
            tod = (m_hours * 3600 + m_minutes * 60 + m_seconds + 1) % 86400;
            m_hours = tod / 3600; m_minutes = (tod / 60) % 60; m_seconds = tod % 60;
        end
    endtask

    // One reference period, at least 5 system clocks long.
    task automatic tick();
        int hi = $urandom_range(3, 2);
        int lo = $urandom_range(4, 3);
        refclk = 1'b1;
        repeat (hi) @(posedge clk);
        #1;
        refclk = 1'b0;
        repeat (lo) @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        @(negedge clk);
    endtask

    // Buttons change right after a fast-strobe edge, so debouncing finishes between strobes.
    task automatic set_buttons(input bit f, input bit h, input bit m);
        while (m_edges % EdgesFast != 0) tick();
        @(posedge clk);
        #1;
        fast_set = f; set_hours = h; set_minutes = m;
        eb_fast = f; eb_hours = h; eb_minutes = m;
        if (h && m) m_seconds = 0;
    endtask

    task automatic step_once();
        int s0 = m_steps;
        for (int i = 0; i < 1024 && m_steps == s0; i++) tick();
    endtask

    task automatic second_once();
        int s0 = m_1hz;
        while (m_1hz == s0) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; refclk = 1'b0; fast_set = 1'b0; set_hours = 1'b0; set_minutes = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({hours, minutes, seconds, stb_1hz} !== {exp_time(), 1'b0}) begin
            tests_failed++;
            $display("FAIL reset: got %0d:%0d:%0d stb=%0b want 0:0:0 stb=0",
                     hours, minutes, seconds, stb_1hz);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_counting();
        repeat (EdgesPerSec - 1) tick();
        settle();
        tests_run++;
        if ({hours, minutes, seconds} !== exp_time() || dut_1hz !== m_1hz) begin
            tests_failed++;
            $display("FAIL count_511: got %0d:%0d:%0d stb=%0d want %0d:%0d:%0d stb=%0d",
                     hours, minutes, seconds, dut_1hz, m_hours, m_minutes, m_seconds, m_1hz);
        end
        tick();
        settle();
        tests_run++;
        if ({hours, minutes, seconds} !== 17'd1 || dut_1hz !== 1) begin
            tests_failed++;
            $display("FAIL count_512: got %0d:%0d:%0d stb=%0d want 0:0:1 stb=1",
                     hours, minutes, seconds, dut_1hz);
        end
    endtask

    task automatic test_fast_hour_set();
        set_buttons(1, 1, 0);
        for (int i = 1; i <= 10; i++) begin
            step_once();
            settle();
            tests_run++;
            if (hours !== 5'(m_hours) || m_hours != i) begin
                tests_failed++;
                $display("FAIL fast_hour_step%0d: got %0d want %0d", i, hours, i);
            end
        end
        set_buttons(0, 0, 0);
        repeat (16) tick();
        settle();
        tests_run++;
        if ({hours, minutes, seconds} !== exp_time()) begin
            tests_failed++;
            $display("FAIL fast_hour_release: got %0d:%0d:%0d want %0d:%0d:%0d",
                     hours, minutes, seconds, m_hours, m_minutes, m_seconds);
        end
    endtask

    task automatic test_minute_set();
        set_buttons(1, 0, 1);
        while (m_minutes != 59) step_once();
        settle();
        tests_run++;
        if ({hours, minutes, seconds} !== exp_time()) begin
            tests_failed++;
            $display("FAIL minute_to_59: got %0d:%0d:%0d want %0d:%0d:%0d",
                     hours, minutes, seconds, m_hours, m_minutes, m_seconds);
        end
        step_once();
        settle();
        tests_run++;
        if ({hours, minutes} !== {5'd10, 6'd0} || {hours, minutes, seconds} !== exp_time()) begin
            tests_failed++;
            $display("FAIL minute_wrap: got %0d:%0d want 10:0", hours, minutes);
        end
        while (m_minutes != 59) step_once();
        settle();
        tests_run++;
        if ({hours, minutes, seconds} !== exp_time()) begin
            tests_failed++;
            $display("FAIL minute_back_to_59: got %0d:%0d:%0d want %0d:%0d:%0d",
                     hours, minutes, seconds, m_hours, m_minutes, m_seconds);
        end
    endtask

    task automatic test_seconds_clear();
        set_buttons(0, 1, 1);
        for (int i = 0; i < 2; i++) begin
            second_once();
            settle();
            tests_run++;
            if ({hours, minutes, seconds} !== exp_time() || seconds !== 6'd0 ||
                dut_1hz !== m_1hz) begin
                tests_failed++;
                $display("FAIL seconds_clear%0d: got %0d:%0d:%0d stb=%0d want %0d:%0d:0 stb=%0d",
                         i, hours, minutes, seconds, dut_1hz, m_hours, m_minutes, m_1hz);
            end
        end
    endtask

    task automatic test_hour_rollover();
        set_buttons(0, 0, 0);
        for (int i = 1; i <= 61; i++) begin
            second_once();
            if (i >= 59) begin
                settle();
                tests_run++;
                if ({hours, minutes, seconds} !== exp_time()) begin
                    tests_failed++;
                    $display("FAIL hour_roll_s%0d: got %0d:%0d:%0d want %0d:%0d:%0d", i,
                             hours, minutes, seconds, m_hours, m_minutes, m_seconds);
                end
            end
        end
        tests_run++;
        if ({hours, minutes, seconds} !== {5'd11, 6'd0, 6'd1}) begin
            tests_failed++;
            $display("FAIL hour_roll_final: got %0d:%0d:%0d want 11:0:1", hours, minutes, seconds);
        end
    endtask

    task automatic test_day_rollover();
        set_buttons(0, 1, 0);
        while (m_hours != 23) step_once();
        set_buttons(1, 0, 1);
        while (m_minutes != 59) step_once();
        set_buttons(0, 1, 1);
        repeat (16) tick();
        set_buttons(0, 0, 0);
        repeat (16) tick();
        settle();
        tests_run++;
        if ({hours, minutes, seconds} !== {5'd23, 6'd59, 6'd0} ||
            {hours, minutes, seconds} !== exp_time()) begin
            tests_failed++;
            $display("FAIL day_setup: got %0d:%0d:%0d want 23:59:0", hours, minutes, seconds);
        end
        for (int i = 1; i <= 61; i++) begin
            second_once();
            if (i >= 60) begin
                settle();
                tests_run++;
                if ({hours, minutes, seconds} !== exp_time() || dut_1hz !== m_1hz) begin
                    tests_failed++;
                    $display("FAIL day_roll_s%0d: got %0d:%0d:%0d stb=%0d want %0d:%0d:%0d stb=%0d",
                             i, hours, minutes, seconds, dut_1hz,
                             m_hours, m_minutes, m_seconds, m_1hz);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int len = $urandom_range(3, 1);
        int h0;
        // Line the pulse up with a slow-set strobe that is not a 1 Hz strobe.
        while (m_edges % EdgesPerSec != EdgesSlow - 1) tick();
        h0 = m_hours;
        set_hours = 1'b1;
`ifndef CLOCK_BUTTON_DEBOUNCE_EN
        eb_hours = 1'b1;
`endif
        repeat (len) tick();
        set_hours = 1'b0;
        eb_hours  = 1'b0;
        repeat (16) tick();
        settle();
        tests_run++;
        if ({hours, minutes, seconds} !== exp_time()) begin
            tests_failed++;
            $display("FAIL glitch_len%0d: got %0d:%0d:%0d want %0d:%0d:%0d (hours before %0d)",
                     len, hours, minutes, seconds, m_hours, m_minutes, m_seconds, h0);
        end
    endtask

    task automatic test_reset_midop();
        repeat ($urandom_range(40, 5)) tick();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({hours, minutes, seconds, stb_1hz} !== 18'd0) begin
            tests_failed++;
            $display("FAIL reset_midop: got %0d:%0d:%0d stb=%0b want 0:0:0 stb=0",
                     hours, minutes, seconds, stb_1hz);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        repeat (EdgesPerSec) tick();
        settle();
        tests_run++;
        if ({hours, minutes, seconds} !== exp_time() || dut_1hz !== m_1hz) begin
            tests_failed++;
            $display("FAIL reset_recount: got %0d:%0d:%0d stb=%0d want %0d:%0d:%0d stb=%0d",
                     hours, minutes, seconds, dut_1hz, m_hours, m_minutes, m_seconds, m_1hz);
        end
    endtask

    initial begin
        reset = 1'b1; refclk = 1'b0; fast_set = 1'b0; set_hours = 1'b0; set_minutes = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_counting();
        test_fast_hour_set();
        test_minute_set();
        test_seconds_clear();
        test_hour_rollover();
        test_day_rollover();
        test_glitch();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
